registers_bank: RTL and testbench
=================================

// Module: registers_bank
// PURPOSE
//   NanoRisc register file: two 4-entry x 8-bit banks, A and B, on one clock.
//   Bank A: A0=$ra, A1=$mem, A2=$t0, A3=$t1. Bank B: B0=$t2, B1..B3 general.
//   Three combinational read ports, plus dedicated $mem and $ra taps.
//   One general write port, plus a memory-load write port into $mem.
//   Sits between decode (register indices), ALU/data memory (data) and control.
// PARAMETERS
//   DATA_W  8  register width
//   ADDR_W  2  register index width (2**ADDR_W entries per bank)
// PORTS
//   clock        in   1       single clock, rising edge
//   reset        in   1       asynchronous, active-high
//   readReg1     in   ADDR_W  bank A index for data1
//   readReg2     in   ADDR_W  bank A index for data2
//   readReg3     in   ADDR_W  bank B index for data3
//   writeReg     in   ADDR_W  write index (bank selected by isSendType0)
//   writeData    in   DATA_W  general write data
//   memWrite     in   DATA_W  memory-load data for $mem (A1)
//   data1        out  DATA_W  A[readReg1]
//   data2        out  DATA_W  A[readReg2]
//   data3        out  DATA_W  B[readReg3]
//   memRead      out  DATA_W  A1 ($mem), always visible
//   raRead       out  DATA_W  A0 ($ra), always visible
//   RegWrite     in   1       enable general write
//   RegMemWrite  in   1       enable memWrite -> A1
//   isSendType0  in   1       1: general write targets bank B; 0: bank A
// BEHAVIOUR
//   - reset high (async): all 8 registers clear to 0 at once; all outputs read 0.
//   - Reads are combinational with zero latency. Without bypass, a read shows
//     the pre-edge value until the next rising edge.
//   - Rising edge, RegWrite=1, isSendType0=0: A[writeReg] <= writeData.
//   - Rising edge, RegWrite=1, isSendType0=1: B[writeReg] <= writeData; A unchanged.
//   - Rising edge, RegMemWrite=1: A1 <= memWrite.
//   - Conflict: RegWrite=1, isSendType0=0, writeReg=1 and RegMemWrite=1 in the
//     same cycle: RegMemWrite wins, A1 <= memWrite.
//   - RegMemWrite=1 with RegWrite to any other A or B entry: both writes happen.
//   - RegWrite=0 and RegMemWrite=0: no state change. isSendType0 is ignored
//     when RegWrite=0.
//   - All indices are in range by width, so no wrap or error cases exist.
//   - Values are stored verbatim; no arithmetic is performed.
//   - reset asserted mid-cycle overrides any pending write; the first write
//     takes effect on the first rising edge after reset deasserts.
// CONFIGURATION
//   REG_BYPASS_EN defined:
//     - data1..3, memRead and raRead forward the value being written this cycle
//       when the port's index and bank match the write target.
//     - Forwarding follows the same priority as the registered write.
//   Undefined: pure registered read, no forwarding.
// STRUCTURE
//   - Package nanorisc_pkg: DATA_W, ADDR_W, and index constants
//     REG_RA=0, REG_MEM=1, REG_T0=2, REG_T1=3, REG_T2=0 (bank B).
//   - Sub-module reg_bank_4x8 is instanced twice (A, B). Each instance has a
//     write enable, a write index and data, async reset, and per-port combinational
//     reads. Bank A also exposes entries 0 and 1 directly.
//   - Top level: write-enable/bank steering, mem-write priority, optional bypass mux.
// TESTING
//   1. Pulse reset -> data1..3, memRead and raRead are all 0.
//   2. Preload A1=2 via RegMemWrite=1, memWrite=2; then RegWrite=1, isSendType0=0,
//      writeReg=2, writeData=2 -> A2=2; readReg1=2 gives data1=2 after the edge.
//   3. isSendType0=1, RegWrite=1, writeReg=0, writeData=2 -> B0=2, A0 stays 0,
//      data3(readReg3=0)=2.
//   4. isSendType0=0, RegWrite=1, writeReg=3, writeData=2 -> A3=2, B3 unchanged.
//   5. Same cycle: RegWrite=1, writeReg=1, writeData=7 and RegMemWrite=1,
//      memWrite=9 -> memRead=9.
//   6. Assert reset between edges with RegWrite=1 -> registers clear immediately
//      and no write occurs; with REG_BYPASS_EN, data1 shows writeData before the edge.

Source files
------------

// File: rtl/nanorisc_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : nanorisc_pkg                                                    |
// | Purpose  : Shared widths, register-index constants and bank selector type |
// |            for the NanoRisc register file.                                 |
// | Contents : DATA_W, ADDR_W, REG_RA/REG_MEM/REG_T0/REG_T1 (bank A),          |
// |            REG_T2 (bank B), bank_e, bank_of()                              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package nanorisc_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;

    // Bank A entries
    localparam logic [ADDR_W-1:0] REG_RA  = 2'd0;
    localparam logic [ADDR_W-1:0] REG_MEM = 2'd1;
    localparam logic [ADDR_W-1:0] REG_T0  = 2'd2;
    localparam logic [ADDR_W-1:0] REG_T1  = 2'd3;
    // Bank B entry
    localparam logic [ADDR_W-1:0] REG_T2  = 2'd0;

    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_e;

    // isSendType0 steers the general write port between the two banks.
    function automatic bank_e bank_of(input logic is_send_type0);
        return is_send_type0 ? BANK_B : BANK_A;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_bank_4x8.sv
// +----------------------------------------------------------------------------+
// | Module   : reg_bank_4x8                                                    |
// | Purpose  : One 2**ADDR_W x DATA_W register bank with a general write port, |
// |            a priority write port and NUM_RD combinational read ports.      |
// | Ports    : clock, reset (async, active-high)                               |
// |            wr_en/wr_idx/wr_data     general write                          |
// |            pri_en/pri_idx/pri_data  write that wins on an index collision  |
// |            rd_idx[NUM_RD]           read indices                           |
// |            rd_data[NUM_RD]          bank[rd_idx], zero latency             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module reg_bank_4x8 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int NUM_RD = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_idx,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           pri_en,
    input  logic [ADDR_W-1:0]              pri_idx,
    input  logic [DATA_W-1:0]              pri_data,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_idx,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    // The priority port is checked first so that a simultaneous general
    // write to the same entry is dropped; writes to distinct entries both land.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                regs[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (pri_en && (pri_idx == ADDR_W'(e))) begin
                    regs[e] <= pri_data;
                end else if (wr_en && (wr_idx == ADDR_W'(e))) begin
                    regs[e] <= wr_data;
                end
            end
        end
    end

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            assign rd_data[p] = regs[rd_idx[p]];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/registers_bank.sv
// +----------------------------------------------------------------------------+
// | Module   : registers_bank                                                  |
// | Purpose  : NanoRisc register file, banks A ($ra,$mem,$t0,$t1) and B       |
// |            ($t2 + 3 general). Steers the general write to bank A or B,     |
// |            gives the memory-load write into $mem priority.                 |
// | Ports    : clock, reset (async, active-high)                               |
// |            readReg1/2 -> data1/2 (bank A), readReg3 -> data3 (bank B)      |
// |            memRead = A1 ($mem), raRead = A0 ($ra)                          |
// |            RegWrite/writeReg/writeData/isSendType0  general write          |
// |            RegMemWrite/memWrite                     load into $mem         |
// | Config   : `define REG_BYPASS_EN forwards same-cycle write data to every   |
// |            read port whose bank/index matches the write target.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module registers_bank #(
    parameter int DATA_W = nanorisc_pkg::DATA_W,
    parameter int ADDR_W = nanorisc_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    input  logic [ADDR_W-1:0] readReg3,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic [DATA_W-1:0] memWrite,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic [DATA_W-1:0] data3,
    output logic [DATA_W-1:0] memRead,
    output logic [DATA_W-1:0] raRead,
    input  logic              RegWrite,
    input  logic              RegMemWrite,
    input  logic              isSendType0
);

    import nanorisc_pkg::*;

    localparam logic [ADDR_W-1:0] IDX_RA  = ADDR_W'(REG_RA);
    localparam logic [ADDR_W-1:0] IDX_MEM = ADDR_W'(REG_MEM);

    bank_e wr_bank;
    logic  a_wr_en;
    logic  b_wr_en;

    assign wr_bank = bank_of(isSendType0);
    assign a_wr_en = RegWrite && (wr_bank == BANK_A);
    assign b_wr_en = RegWrite && (wr_bank == BANK_B);

    // Bank A read ports: 0=readReg1, 1=readReg2, 2=$ra tap, 3=$mem tap
    logic [3:0][ADDR_W-1:0] a_rd_idx;
    logic [3:0][DATA_W-1:0] a_rd_data;
    logic [0:0][ADDR_W-1:0] b_rd_idx;
    logic [0:0][DATA_W-1:0] b_rd_data;

    assign a_rd_idx = {IDX_MEM, IDX_RA, readReg2, readReg1};
    assign b_rd_idx = readReg3;

    reg_bank_4x8 #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (4)
    ) u_bank_a (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (a_wr_en),
        .wr_idx   (writeReg),
        .wr_data  (writeData),
        .pri_en   (RegMemWrite),
        .pri_idx  (IDX_MEM),
        .pri_data (memWrite),
        .rd_idx   (a_rd_idx),
        .rd_data  (a_rd_data)
    );

    // Bank B has no memory-load path; its priority port is tied off.
    reg_bank_4x8 #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (1)
    ) u_bank_b (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (b_wr_en),
        .wr_idx   (writeReg),
        .wr_data  (writeData),
        .pri_en   (1'b0),
        .pri_idx  ('0),
        .pri_data ('0),
        .rd_idx   (b_rd_idx),
        .rd_data  (b_rd_data)
    );

`ifdef REG_BYPASS_EN
    // Same priority as the registered write: the $mem load beats a general
    // write to A1. Forwarding is not gated by reset, so a pending write is
    // visible on the read ports even while the registers are held clear.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [ADDR_W-1:0] idx,
        input logic [DATA_W-1:0] stored,
        input logic              gen_en,
        input logic [ADDR_W-1:0] gen_idx,
        input logic [DATA_W-1:0] gen_data,
        input logic              pri_en,
        input logic [DATA_W-1:0] pri_data
    );
        if (pri_en && (idx == IDX_MEM)) begin
            return pri_data;
        end else if (gen_en && (idx == gen_idx)) begin
            return gen_data;
        end
        return stored;
    endfunction

    always_comb begin
        data1   = fwd(readReg1, a_rd_data[0], a_wr_en, writeReg, writeData, RegMemWrite, memWrite);
        data2   = fwd(readReg2, a_rd_data[1], a_wr_en, writeReg, writeData, RegMemWrite, memWrite);
        raRead  = fwd(IDX_RA,   a_rd_data[2], a_wr_en, writeReg, writeData, RegMemWrite, memWrite);
        memRead = fwd(IDX_MEM,  a_rd_data[3], a_wr_en, writeReg, writeData, RegMemWrite, memWrite);
        data3   = fwd(readReg3, b_rd_data[0], b_wr_en, writeReg, writeData, 1'b0, '0);
    end
`else
    always_comb begin
        data1   = a_rd_data[0];
        data2   = a_rd_data[1];
        raRead  = a_rd_data[2];
        memRead = a_rd_data[3];
        data3   = b_rd_data[0];
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_registers_bank.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_registers_bank                                               |
// | Purpose  : Directed self-checking bench for registers_bank. Expected      |
// |            values are hand-computed; REG_BYPASS_EN selects the forwarded   |
// |            expectations where a write is pending during a check.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_registers_bank;

    logic       clock;
    logic       reset;
    logic [1:0] readReg1, readReg2, readReg3, writeReg;
    logic [7:0] writeData, memWrite;
    logic [7:0] data1, data2, data3, memRead, raRead;
    logic       RegWrite, RegMemWrite, isSendType0;

    int total;
    int bad;

`ifdef REG_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    registers_bank dut (
        .clock       (clock),
        .reset       (reset),
        .readReg1    (readReg1),
        .readReg2    (readReg2),
        .readReg3    (readReg3),
        .writeReg    (writeReg),
        .writeData   (writeData),
        .memWrite    (memWrite),
        .data1       (data1),
        .data2       (data2),
        .data3       (data3),
        .memRead     (memRead),
        .raRead      (raRead),
        .RegWrite    (RegWrite),
        .RegMemWrite (RegMemWrite),
        .isSendType0 (isSendType0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then drop the write enables so later checks
    // see pure register contents.
    task automatic step();
        @(posedge clock);
        #1;
        RegWrite    = 1'b0;
        RegMemWrite = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        readReg1 = 2'd1; readReg2 = 2'd2; readReg3 = 2'd3; writeReg = 2'd0;
        writeData = 8'h00; memWrite = 8'h00;
        RegWrite = 1'b0; RegMemWrite = 1'b0; isSendType0 = 1'b0;

        // 1. reset state
        @(posedge clock); @(posedge clock); #1;
        check("rst_data1",   data1,   8'h00);
        check("rst_data2",   data2,   8'h00);
        check("rst_data3",   data3,   8'h00);
        check("rst_memRead", memRead, 8'h00);
        check("rst_raRead",  raRead,  8'h00);
        reset = 1'b0;
        step();

        // 2. preload $mem, then A2
        RegMemWrite = 1'b1; memWrite = 8'h02;
        step();
        check("mem_preload", memRead, 8'h02);
        RegWrite = 1'b1; isSendType0 = 1'b0; writeReg = 2'd2; writeData = 8'h02;
        readReg1 = 2'd2;
        #1;
        check("a2_pre_edge", data1, BYP ? 8'h02 : 8'h00);
        step();
        check("a2_write", data1, 8'h02);

        // 3. bank B write, A0 untouched
        RegWrite = 1'b1; isSendType0 = 1'b1; writeReg = 2'd0; writeData = 8'h02;
        readReg3 = 2'd0; readReg1 = 2'd0;
        step();
        check("b0_write", data3,  8'h02);
        check("a0_raRead", raRead, 8'h00);
        check("a0_data1",  data1,  8'h00);

        // 4. A3 write, B3 untouched
        RegWrite = 1'b1; isSendType0 = 1'b0; writeReg = 2'd3; writeData = 8'h02;
        readReg2 = 2'd3; readReg3 = 2'd3;
        step();
        check("a3_write", data2, 8'h02);
        check("b3_clean", data3, 8'h00);

        // 5. conflict on A1: memory load wins
        RegWrite = 1'b1; isSendType0 = 1'b0; writeReg = 2'd1; writeData = 8'h07;
        RegMemWrite = 1'b1; memWrite = 8'h09; readReg1 = 2'd1;
        #1;
        check("conflict_pre_mem",   memRead, BYP ? 8'h09 : 8'h02);
        check("conflict_pre_data1", data1,   BYP ? 8'h09 : 8'h02);
        step();
        check("conflict_memRead", memRead, 8'h09);
        check("conflict_data1",   data1,   8'h09);

        // both writes land when targets differ (B1 and $mem)
        RegWrite = 1'b1; isSendType0 = 1'b1; writeReg = 2'd1; writeData = 8'h05;
        RegMemWrite = 1'b1; memWrite = 8'h04; readReg3 = 2'd1;
        step();
        check("dual_memRead", memRead, 8'h04);
        check("dual_b1",      data3,   8'h05);

        // no enables: no state change, isSendType0 ignored
        writeData = 8'hAA; memWrite = 8'hBB; isSendType0 = 1'b0; writeReg = 2'd1;
        step();
        check("idle_b1",  data3,   8'h05);
        check("idle_mem", memRead, 8'h04);
        readReg1 = 2'd2;
        #1;
        check("idle_a2",  data1,   8'h02);

        // 6. async reset mid-cycle with a pending write
        RegWrite = 1'b1; isSendType0 = 1'b0; writeReg = 2'd2; writeData = 8'h55;
        #2;
        reset = 1'b1;
        #1;
        check("arst_data1",   data1,   BYP ? 8'h55 : 8'h00);
        check("arst_memRead", memRead, 8'h00);
        RegWrite = 1'b0;
        #1;
        check("arst_a2_clear", data1, 8'h00);
        check("arst_a3_clear", data2, 8'h00);
        check("arst_b1_clear", data3, 8'h00);
        // hold reset across an edge with a write requested
        RegWrite = 1'b1;
        @(posedge clock); #1;
        RegWrite = 1'b0;
        #1;
        check("arst_hold_a2", data1, 8'h00);
        reset = 1'b0;
        RegWrite = 1'b1; writeReg = 2'd2; writeData = 8'h33;
        step();
        check("post_rst_a2", data1, 8'h33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
